// File: rtl/instr_enc.sv
// instr_enc: MIPS-style instruction encoder feeding a 256-word instruction-memory write channel.
// Shift mnemonics (codes 11-14) are encoded only when INSTR_ENC_SHIFT_EN is defined; otherwise they are illegal.
module instr_enc (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_addr,
  output logic [31:0] out_word,
  output logic        full,
  output logic        err,
  output logic [7:0]  err_addr
);
  logic        legal, i_fmt, j_fmt, keep_rs, keep_rt, keep_rd, keep_sh;
  logic [5:0]  op, funct;
  logic [4:0]  rs_f, rt_f, rd_f, sh_f;
  logic [31:0] enc_word;
  logic        accept, hs, bad;
  logic        out_valid_d, out_valid_q, full_d, full_q, err_d, err_q;
  logic [7:0]  out_addr_d, out_addr_q, err_addr_d, err_addr_q;
  logic [31:0] out_word_d, out_word_q;

  always_comb begin
    legal   = 1'b1;
    i_fmt   = 1'b0;
    j_fmt   = 1'b0;
    keep_rs = 1'b1;
    keep_rt = 1'b1;
    keep_rd = 1'b1;
    keep_sh = 1'b0;
    op      = 6'h00;
    funct   = 6'h00;
    case (in_mnem)
      5'd0:  funct = 6'h20;
      5'd1:  funct = 6'h22;
      5'd2:  funct = 6'h24;
      5'd3:  funct = 6'h25;
      5'd4:  funct = 6'h2A;
      5'd5:  funct = 6'h2B;
      5'd6:  funct = 6'h21;
      5'd7:  funct = 6'h23;
      5'd8:  funct = 6'h27;
      5'd9:  begin funct = 6'h08; keep_rt = 1'b0; keep_rd = 1'b0; end
      5'd10: begin funct = 6'h09; keep_rt = 1'b0; end
`ifdef INSTR_ENC_SHIFT_EN
      5'd11: begin funct = 6'h00; keep_rs = 1'b0; keep_sh = 1'b1; end
      5'd12: begin funct = 6'h02; keep_rs = 1'b0; keep_sh = 1'b1; end
      5'd13: funct = 6'h04;
      5'd14: funct = 6'h06;
`endif
      5'd15: begin i_fmt = 1'b1; op = 6'h08; end
      5'd16: begin i_fmt = 1'b1; op = 6'h0D; end
      5'd17: begin i_fmt = 1'b1; op = 6'h23; end
      5'd18: begin i_fmt = 1'b1; op = 6'h2B; end
      5'd19: begin i_fmt = 1'b1; op = 6'h04; end
      5'd20: begin i_fmt = 1'b1; op = 6'h05; end
      5'd21: begin i_fmt = 1'b1; op = 6'h0C; end
      5'd22: begin i_fmt = 1'b1; op = 6'h0A; end
      5'd23: begin i_fmt = 1'b1; op = 6'h0F; keep_rs = 1'b0; end
      5'd24: begin j_fmt = 1'b1; op = 6'h02; end
      5'd25: begin j_fmt = 1'b1; op = 6'h03; end
      default: legal = 1'b0;
    endcase
    rs_f     = keep_rs ? in_rs : 5'd0;
    rt_f     = keep_rt ? in_rt : 5'd0;
    rd_f     = keep_rd ? in_rd : 5'd0;
    sh_f     = keep_sh ? in_shamt : 5'd0;
    enc_word = j_fmt ? {op, in_target} :
               i_fmt ? {op, rs_f, in_rt, in_imm} :
                       {6'h00, rs_f, rt_f, rd_f, sh_f, funct};
  end

  assign hs       = out_valid_q & out_ready;
  assign in_ready = ~full_q & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign bad      = accept & ~legal;

  // Illegal requests are consumed silently apart from the sticky error capture.
  always_comb begin
    out_valid_d = (accept & legal) | (out_valid_q & ~hs);
    out_word_d  = (accept & legal) ? enc_word : out_word_q;
    out_addr_d  = hs ? out_addr_q + 8'd1 : out_addr_q;
    full_d      = full_q | (hs & (out_addr_q == 8'hFF));
    err_d       = err_q | bad;
    err_addr_d  = (bad & ~err_q) ? out_addr_q : err_addr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_word_q  <= 32'd0;
      out_addr_q  <= 8'd0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      full_q      <= full_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign full      = full_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc: scoreboard bench for instr_enc; directed requests push expected {addr,word}, a monitor pops on each handshake.
module tb_instr_enc;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_addr;
  logic [31:0] out_word;
  logic        full, err;
  logic [7:0]  err_addr;

  int checks = 0;
  int failures = 0;
  logic [39:0] sb[$];
  logic [7:0]  exp_addr = 8'd0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word;
  logic [7:0]  prev_addr;

  instr_enc dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_word(out_word),
    .full(full), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Callers are aligned just after a rising edge; returns aligned the same way.
  task automatic send(input logic [4:0] m, rs, rt, rd, sh, input logic [15:0] imm,
                      input logic [25:0] tg, input logic legal, input logic [31:0] w, output int waits);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tg;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout mnem=%0d in_ready=%0b required=1", m, in_ready);
      in_valid = 1'b0;
      tick();
    end else begin
      @(posedge clk);
      if (legal) begin
        sb.push_back({exp_addr, w});
        exp_addr++;
      end
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_err_addr", err_addr, 0);
    sb.delete();
    exp_addr = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", out_word, prev_word);
        chk("hold_addr", out_addr, prev_addr);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h@%0d expected=none", out_word, out_addr);
        end else begin
          logic [39:0] e;
          e = sb.pop_front();
          chk("sb_addr", out_addr, e[39:32]);
          chk("sb_word", out_word, e[31:0]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_word;
      prev_addr  = out_addr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tick();
    do_reset();
    // R/I/J encodings, including zeroing of unused fields
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00221820, w);
    chk("lat_valid", out_valid, 1);
    chk("lat_word", out_word, 32'h00221820);
    chk("lat_addr", out_addr, 0);
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0, 1'b1, 32'h00221822, w);
    send(5'd9, 5'd31, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h0, 1'b1, 32'h03E00008, w);
    send(5'd10, 5'd4, 5'd5, 5'd31, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0080F809, w);
    send(5'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b1, 32'h8FA8FFFC, w);
    send(5'd16, 5'd2, 5'd3, 5'd7, 5'd7, 16'h00FF, 26'h0, 1'b1, 32'h344300FF, w);
    send(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h3FFFFFF, 1'b1, 32'h0FFFFFFF, w);
    send(5'd23, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h3C011234, w);
    drain();
    // illegal codes: sticky err, first address only, no address advance
    send(5'd26, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 32'h0, w);
    chk("ill_err", err, 1);
    chk("ill_err_addr", err_addr, 8);
    chk("ill_no_word", out_valid, 0);
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0, w);
    chk("ill2_err_addr", err_addr, 8);
    send(5'd2, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00E84824, w);
    drain();
    // shift mnemonics depend on build configuration
    do_reset();
`ifdef INSTR_ENC_SHIFT_EN
    send(5'd11, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1, 32'h00011100, w);
    send(5'd12, 5'd3, 5'd1, 5'd2, 5'd31, 16'h0, 26'h0, 1'b1, 32'h000117C2, w);
    drain();
    chk("shift_no_err", err, 0);
`else
    send(5'd11, 5'd0, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, 32'h0, w);
    chk("shift_err", err, 1);
    chk("shift_err_addr", err_addr, 0);
    chk("shift_no_word", out_valid, 0);
    send(5'd12, 5'd3, 5'd1, 5'd2, 5'd31, 16'h0, 26'h0, 1'b0, 32'h0, w);
    chk("shift_addr_held", out_addr, 0);
`endif
    // backpressure then back-to-back
    do_reset();
    out_ready = 1'b0;
    send(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 32'h08000010, w);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_word", out_word, 32'h08000010);
      chk("bp_in_ready", in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00221820, w);
    chk("b2b_wait1", w, 0);
    send(5'd16, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b1, 32'h344300FF, w);
    chk("b2b_wait2", w, 0);
    drain();
    chk("b2b_addr", out_addr, 3);
    // reset mid-stream discards the pending word and the error
    do_reset();
    out_ready = 1'b0;
    send(5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0, w);
    send(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00221825, w);
    chk("mid_pending", out_valid, 1);
    chk("mid_err", err, 1);
    do_reset();
    out_ready = 1'b1;
    tick();
    chk("mid_discarded", out_valid, 0);
    // capacity: 256 words fill the memory
    for (int i = 0; i < 256; i++) begin
      logic [4:0]  rs, rt;
      logic [15:0] imm;
      rs  = 5'(i);
      rt  = 5'(i >> 3);
      imm = 16'(i * 7);
      send(5'd15, rs, rt, 5'd0, 5'd0, imm, 26'h0, 1'b1, {6'h08, rs, rt, imm}, w);
    end
    drain();
    tick();
    chk("cap_full", full, 1);
    chk("cap_in_ready", in_ready, 0);
    chk("cap_out_addr", out_addr, 0);
    chk("cap_out_valid", out_valid, 0);
    in_mnem = 5'd0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("cap_blocked", in_ready, 0);
    end
    tick();
    in_valid = 1'b0;
    tick();
    chk("cap_no_word", out_valid, 0);
    do_reset();
    chk("cap_reset_full", full, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
